// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared state encoding and byte-0 field positions for the PS/2 mouse packet decoder (rev 1.0)
`default_nettype none

package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_e;

  localparam int SYNC_BIT        = 3;
  localparam int XS_BIT          = 4;
  localparam int YS_BIT          = 5;
  localparam int XO_BIT          = 6;
  localparam int YO_BIT          = 7;
  localparam int BTN_LSB         = 0;
  localparam int DEFAULT_TIMEOUT = 100000;

endpackage

`default_nettype wire

// File: rtl/ps2_axis_accum.sv
// ps2_axis_accum: saturating add of a signed delta to a cursor coordinate, clamped to [0, MAX] (rev 1.0)
`default_nettype none

module ps2_axis_accum #(
  parameter int MAX = 639
) (
  input  logic              [9:0] pos_i,
  // 10 bits so the Y axis can carry the negation of -256 without wrapping
  input  logic signed       [9:0] delta_i,
  input  logic                    hold_i,
  output logic              [9:0] pos_o
);

  localparam logic signed [11:0] MAX_S = 12'(MAX);

  logic signed [11:0] sum;

  always_comb begin
    sum   = $signed({2'b00, pos_i}) + $signed({{2{delta_i[9]}}, delta_i});
    pos_o = pos_i;
    if (!hold_i) begin
      if (sum[11]) begin
        pos_o = '0;
      end else if (sum > MAX_S) begin
        pos_o = MAX_S[9:0];
      end else begin
        pos_o = sum[9:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_packet.sv
// ps2_mouse_packet: assembles 3-byte PS/2 stream packets, decodes buttons/deltas, integrates cursor (rev 1.0)
`default_nettype none

module ps2_mouse_packet
  import ps2_mouse_pkg::*;
#(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stream_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       pkt_valid_o,
  output logic [2:0] btn_o,
  output logic [8:0] dx_o,
  output logic [8:0] dy_o,
  output logic [1:0] ovf_o,
  output logic [9:0] pos_x_o,
  output logic [9:0] pos_y_o,
  output logic       sync_err_o
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         b0_q, b0_d, b1_q, b1_d;
  logic [2:0]         btn_q, btn_d;
  logic [8:0]         dx_q, dx_d, dy_q, dy_d;
  logic [1:0]         ovf_q, ovf_d;
  logic [9:0]         posx_q, posx_d, posy_q, posy_d;
  logic               pkt_q, pkt_d, err_q, err_d;

  logic [8:0]         dx_new, dy_new;
  logic signed [9:0]  dx_ext, dy_neg;
  logic [9:0]         nx, ny;
  logic               expired;

  assign dx_new  = {b0_q[XS_BIT], b1_q};
  assign dy_new  = {b0_q[YS_BIT], rx_data_i};
  assign dx_ext  = $signed({dx_new[8], dx_new});
  assign dy_neg  = -$signed({dy_new[8], dy_new});
  assign expired = (state_q != WAIT_B0) && (cnt_q == CNT_LAST);

  ps2_axis_accum #(.MAX(X_MAX)) u_acc_x (
    .pos_i   (posx_q),
    .delta_i (dx_ext),
    .hold_i  (b0_q[XO_BIT]),
    .pos_o   (nx)
  );

  ps2_axis_accum #(.MAX(Y_MAX)) u_acc_y (
    .pos_i   (posy_q),
    .delta_i (dy_neg),
    .hold_i  (b0_q[YO_BIT]),
    .pos_o   (ny)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    btn_d   = btn_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    ovf_d   = ovf_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    pkt_d   = 1'b0;
    err_d   = 1'b0;

    if (!stream_i) begin
      state_d = WAIT_B0;
      cnt_d   = '0;
    end else if (rx_valid_i) begin
      // An arriving byte always beats a coincident timeout expiry
      cnt_d = '0;
      case (state_q)
        WAIT_B0: begin
          if (rx_data_i[SYNC_BIT]) begin
            b0_d    = rx_data_i;
            state_d = WAIT_B1;
          end else begin
            err_d = 1'b1;
          end
        end
        WAIT_B1: begin
          b1_d    = rx_data_i;
          state_d = WAIT_B2;
        end
        WAIT_B2: begin
          btn_d   = b0_q[BTN_LSB +: 3];
          dx_d    = dx_new;
          dy_d    = dy_new;
          ovf_d   = {b0_q[YO_BIT], b0_q[XO_BIT]};
          posx_d  = nx;
          posy_d  = ny;
          pkt_d   = 1'b1;
          state_d = WAIT_B0;
        end
        default: state_d = WAIT_B0;
      endcase
    end else if (expired) begin
      state_d = WAIT_B0;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else if (state_q != WAIT_B0) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_B0;
      cnt_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      btn_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      ovf_q   <= '0;
      posx_q  <= 10'(X_INIT);
      posy_q  <= 10'(Y_INIT);
      pkt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      btn_q   <= btn_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      ovf_q   <= ovf_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign pkt_valid_o = pkt_q;
  assign sync_err_o  = err_q;
  assign btn_o       = btn_q;
  assign dx_o        = dx_q;
  assign dy_o        = dy_q;
  assign ovf_o       = ovf_q;
  assign pos_x_o     = posx_q;
  assign pos_y_o     = posy_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_packet.sv
// tb_ps2_mouse_packet: directed plan plus randomized traffic against a packet-level reference model (rev 1.0)
`default_nettype none

module tb_ps2_mouse_packet;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst, stream, rx_valid;
  logic [7:0] rx_data;
  logic       pkt_valid, sync_err;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic [1:0] ovf;
  logic [9:0] pos_x, pos_y;

  ps2_mouse_packet #(
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stream_i(stream), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .pkt_valid_o(pkt_valid), .btn_o(btn), .dx_o(dx),
    .dy_o(dy), .ovf_o(ovf), .pos_x_o(pos_x), .pos_y_o(pos_y), .sync_err_o(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: packet-level view of the byte stream
  logic [7:0] pq[$];
  int         idle, m_px, m_py, m_dx, m_dy;
  logic [2:0] m_btn;
  logic [1:0] m_ovf;
  bit         e_pkt, e_err;
  int         pkt_seen = 0, err_seen = 0, strobe_bad = 0;

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [42:0] exp_vec();
    return {m_btn, 9'(m_dx), 9'(m_dy), m_ovf, 10'(m_px), 10'(m_py)};
  endfunction

  task automatic model_reset();
    m_px = 320; m_py = 240; m_dx = 0; m_dy = 0; m_btn = 0; m_ovf = 0;
    pq.delete(); idle = 0;
  endtask

  task automatic model(input bit s, input bit v, input logic [7:0] d);
    logic [7:0] b0, b1;
    e_pkt = 0; e_err = 0;
    if (!s) begin
      pq.delete(); idle = 0;
    end else if (v) begin
      if (pq.size() == 0 && !d[3]) begin
        e_err = 1;
      end else begin
        pq.push_back(d); idle = 0;
        if (pq.size() == 3) begin
          b0 = pq[0]; b1 = pq[1];
          m_btn = b0[2:0];
          m_dx  = b0[4] ? int'(b1) - 256 : int'(b1);
          m_dy  = b0[5] ? int'(d) - 256 : int'(d);
          m_ovf = {b0[7], b0[6]};
          if (!b0[6]) m_px = clampi(m_px + m_dx, 639);
          if (!b0[7]) m_py = clampi(m_py - m_dy, 479);
          e_pkt = 1;
          pq.delete();
        end
      end
    end else if (pq.size() > 0) begin
      idle++;
      if (idle == TO) begin
        e_err = 1; pq.delete(); idle = 0;
      end
    end
  endtask

  task automatic step(input bit s, input bit v, input logic [7:0] d);
    @(negedge clk);
    stream = s; rx_valid = v; rx_data = d;
    model(s, v, d);
    @(posedge clk); #1;
    if (pkt_valid) pkt_seen++;
    if (sync_err) err_seen++;
    if (pkt_valid !== e_pkt || sync_err !== e_err) strobe_bad++;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    step(1, 1, a); step(1, 1, b); step(1, 1, c);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; stream = 1; rx_valid = 0; rx_data = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    int p0, e0, s0;
    do_reset();
    p0 = pkt_seen; e0 = err_seen; s0 = strobe_bad;
    idle_n(20);
    checks++; if (pos_x !== 10'd320) begin errors++; $display("FAIL reset_pos_x got %0d want 320", pos_x); end
    checks++; if (pos_y !== 10'd240) begin errors++; $display("FAIL reset_pos_y got %0d want 240", pos_y); end
    checks++; if ({btn, dx, dy, ovf} !== 23'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {btn, dx, dy, ovf}); end
    checks++; if (pkt_seen - p0 + err_seen - e0 + strobe_bad - s0 !== 0) begin
      errors++; $display("FAIL reset_strobes got %0d pulses want 0", pkt_seen - p0 + err_seen - e0); end
  endtask

  task automatic test_basic();
    int p0;
    p0 = pkt_seen;
    send3(8'h09, 8'h05, 8'h03);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_pkt_timing got %b want 1", pkt_valid); end
    idle_n(2);
    checks++; if (pkt_seen - p0 !== 1) begin errors++; $display("FAIL basic_pkt_count got %0d want 1", pkt_seen - p0); end
    checks++; if (btn !== 3'b001 || dx !== 9'd5 || dy !== 9'd3 || ovf !== 2'b00) begin
      errors++; $display("FAIL basic_fields got btn=%b dx=%0d dy=%0d ovf=%b want 001 5 3 00", btn, dx, dy, ovf); end
    checks++; if (pos_x !== 10'd325 || pos_y !== 10'd237) begin
      errors++; $display("FAIL basic_pos got %0d,%0d want 325,237", pos_x, pos_y); end
  endtask

  task automatic test_negative_and_ovf();
    do_reset();
    send3(8'h38, 8'hFB, 8'hFE);
    checks++; if (dx !== 9'h1FB || dy !== 9'h1FE) begin errors++; $display("FAIL neg_delta got dx=%h dy=%h want 1fb 1fe", dx, dy); end
    checks++; if (pos_x !== 10'd315 || pos_y !== 10'd242) begin errors++; $display("FAIL neg_pos got %0d,%0d want 315,242", pos_x, pos_y); end
    send3(8'h48, 8'h10, 8'h00);
    checks++; if (ovf !== 2'b01 || dx !== 9'd16) begin errors++; $display("FAIL ovf_fields got ovf=%b dx=%0d want 01 16", ovf, dx); end
    checks++; if (pos_x !== 10'd315 || pos_y !== 10'd242) begin errors++; $display("FAIL ovf_hold got %0d,%0d want 315,242", pos_x, pos_y); end
  endtask

  task automatic test_sync_err();
    int p0, e0, x0;
    p0 = pkt_seen; e0 = err_seen; x0 = m_px;
    step(1, 1, 8'h00);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL sync_err_pulse got %b want 1", sync_err); end
    send3(8'h08, 8'h01, 8'h00);
    idle_n(1);
    checks++; if (err_seen - e0 !== 1 || pkt_seen - p0 !== 1) begin
      errors++; $display("FAIL sync_counts got err=%0d pkt=%0d want 1 1", err_seen - e0, pkt_seen - p0); end
    checks++; if (dx !== 9'd1 || pos_x !== 10'(x0 + 1)) begin errors++; $display("FAIL sync_recover got dx=%0d x=%0d want 1 %0d", dx, pos_x, x0 + 1); end
  endtask

  task automatic test_clamp();
    int want_hi[3] = '{575, 639, 639};
    int want_lo[3] = '{65, 0, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send3(8'h08, 8'hFF, 8'h00);
      checks++; if (pos_x !== 10'(want_hi[i])) begin errors++; $display("FAIL clamp_hi[%0d] got %0d want %0d", i, pos_x, want_hi[i]); end
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send3(8'h18, 8'h01, 8'h00);
      checks++; if (pos_x !== 10'(want_lo[i])) begin errors++; $display("FAIL clamp_lo[%0d] got %0d want %0d", i, pos_x, want_lo[i]); end
    end
    checks++; if (pos_y !== 10'd240) begin errors++; $display("FAIL clamp_y got %0d want 240", pos_y); end
  endtask

  task automatic test_timeout();
    int p0, e0, x0;
    p0 = pkt_seen; e0 = err_seen; x0 = m_px;
    step(1, 1, 8'h08); step(1, 1, 8'h10);
    idle_n(TO - 1);
    checks++; if (err_seen - e0 !== 0) begin errors++; $display("FAIL timeout_early got %0d errs want 0", err_seen - e0); end
    idle_n(1);
    checks++; if (sync_err !== 1'b1 || pkt_seen - p0 !== 0) begin
      errors++; $display("FAIL timeout_pulse got err=%b pkts=%0d want 1 0", sync_err, pkt_seen - p0); end
    send3(8'h08, 8'h02, 8'h00);
    checks++; if (dx !== 9'd2 || pos_x !== 10'(x0 + 2)) begin errors++; $display("FAIL timeout_recover got dx=%0d x=%0d want 2 %0d", dx, pos_x, x0 + 2); end
    // byte landing on the expiry cycle must be accepted
    e0 = err_seen; p0 = pkt_seen;
    step(1, 1, 8'h08); idle_n(TO - 1); step(1, 1, 8'h01); idle_n(TO - 1); step(1, 1, 8'h00);
    idle_n(1);
    checks++; if (err_seen - e0 !== 0 || pkt_seen - p0 !== 1 || dx !== 9'd1) begin
      errors++; $display("FAIL timeout_edge got err=%0d pkt=%0d dx=%0d want 0 1 1", err_seen - e0, pkt_seen - p0, dx); end
  endtask

  task automatic test_stream_drop();
    int p0, e0, s0;
    logic [9:0] x0, y0;
    p0 = pkt_seen; e0 = err_seen; s0 = strobe_bad; x0 = pos_x; y0 = pos_y;
    step(1, 1, 8'h08); step(1, 1, 8'h10);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
    idle_n(TO + 5);
    checks++; if (pkt_seen - p0 !== 0 || err_seen - e0 !== 0 || strobe_bad !== s0) begin
      errors++; $display("FAIL stream_strobes got pkt=%0d err=%0d want 0 0", pkt_seen - p0, err_seen - e0); end
    checks++; if (pos_x !== x0 || pos_y !== y0) begin errors++; $display("FAIL stream_pos got %0d,%0d want %0d,%0d", pos_x, pos_y, x0, y0); end
  endtask

  task automatic test_back_to_back();
    int p0, x0;
    p0 = pkt_seen; x0 = m_px;
    send3(8'h09, 8'h01, 8'h00); send3(8'h08, 8'h01, 8'h00);
    idle_n(1);
    checks++; if (pkt_seen - p0 !== 2 || pos_x !== 10'(x0 + 2) || btn !== 3'b000) begin
      errors++; $display("FAIL b2b got pkt=%0d x=%0d btn=%b want 2 %0d 000", pkt_seen - p0, pos_x, btn, x0 + 2); end
  endtask

  task automatic test_async_reset();
    int p0, e0;
    do_reset();
    send3(8'h09, 8'h05, 8'h03);
    step(1, 1, 8'h08); step(1, 1, 8'h05);
    @(negedge clk); rx_valid = 0; #2 rst = 1; #1;
    checks++; if (pos_x !== 10'd320 || btn !== 3'b000) begin
      errors++; $display("FAIL async_reset got x=%0d btn=%b want 320 000", pos_x, btn); end
    model_reset();
    @(negedge clk); rst = 0;
    p0 = pkt_seen; e0 = err_seen;
    step(1, 1, 8'h03);
    checks++; if (err_seen - e0 !== 1 || pkt_seen - p0 !== 0) begin
      errors++; $display("FAIL async_discard got err=%0d pkt=%0d want 1 0", err_seen - e0, pkt_seen - p0); end
  endtask

  task automatic test_random();
    int mode, n;
    bit s, v;
    logic [7:0] d;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      mode = $urandom_range(0, 99);
      n = (mode < 5) ? $urandom_range(1, 3) : (mode < 70) ? 1 : (mode < 95) ? $urandom_range(1, 3) : $urandom_range(TO - 1, TO + 1);
      for (int k = 0; k < n; k++) begin
        s = (mode >= 5);
        v = (mode < 70);
        d = 8'($urandom);
        if (mode >= 5 && mode < 70 && pq.size() == 0 && $urandom_range(0, 9) != 0) d[3] = 1'b1;
        step(s, v, d);
        checks++; if (pkt_valid !== e_pkt || sync_err !== e_err) begin
          errors++; $display("FAIL rand_strobe[%0d] got pkt=%b err=%b want %b %b", it, pkt_valid, sync_err, e_pkt, e_err); end
        checks++; if ({btn, dx, dy, ovf, pos_x, pos_y} !== exp_vec()) begin
          errors++; $display("FAIL rand_outputs[%0d] got %h want %h", it, {btn, dx, dy, ovf, pos_x, pos_y}, exp_vec()); end
      end
    end
  endtask

  initial begin
    rst = 1; stream = 1; rx_valid = 0; rx_data = 0;
    model_reset();
    test_reset();
    test_basic();
    test_negative_and_ovf();
    test_sync_err();
    test_clamp();
    test_timeout();
    test_stream_drop();
    test_back_to_back();
    test_async_reset();
    test_random();
    checks++; if (strobe_bad !== 0) begin errors++; $display("FAIL strobe_timing got %0d bad cycles want 0", strobe_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
